dunit_pipe_sequencer: RTL and testbench
=======================================

# dunit_pipe_sequencer

Debug-unit sequencer that generates `o_dunit_clk_en`, the shared clock enable for every MIPS pipeline stage register (IF/ID, ID/EX, EX/M, M/WB) and the PC. Accepts run/step/stop commands from the UART debug unit, and drains the pipeline after a HALT instruction so in-flight instructions retire before the core freezes. It also keeps a retired-cycle counter for the debug report.

## Interface
- `NB_CNT`, 32: width of the cycle counter.
- `DRAIN_CYCLES`, 4: enabled cycles granted after HALT detection (stages behind ID); legal range 1..15.
- `CYCLE_LIMIT`, 32'd1_000_000: watchdog limit, used only with `DUNIT_WATCHDOG_EN`.

Ports:
- `i_clk`  in  1  system clock, all state on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_run_req`  in  1  level/pulse, start continuous execution.
- `i_step_req`  in  1  pulse, advance pipeline one cycle.
- `i_stop_req`  in  1  pulse, pause continuous execution (resumable).
- `i_clear`  in  1  pulse, leave HALTED, zero counter.
- `i_halt_detect`  in  1  HALT opcode decoded in ID this cycle.
- `o_dunit_clk_en`  out  1  pipeline register enable.
- `o_state`  out  3  current state encoding.
- `o_halted`  out  1  high in HALTED.
- `o_step_done`  out  1  one-cycle pulse after a step completes.
- `o_timeout`  out  1  sticky watchdog flag (constant 0 without macro).
- `o_cycle_count`  out  NB_CNT  number of enabled cycles since reset/clear.

## Operation
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; values 5-7 are illegal and return to IDLE on the next edge.
- `o_dunit_clk_en` = 1 exactly when the state is RUN, STEP or DRAIN. It is decoded from the state register, so it is glitch-free and has no combinational path from the inputs.
- IDLE: `i_run_req` -> RUN; otherwise `i_step_req` -> STEP (run has priority); `i_stop_req`/`i_clear` ignored.
- RUN: `i_halt_detect` -> DRAIN, drain counter loaded with DRAIN_CYCLES; otherwise `i_stop_req` -> IDLE (halt_detect wins over stop); run/step requests ignored.
- STEP: always leaves after one cycle: `i_halt_detect` -> DRAIN (loaded as above), else -> IDLE with `o_step_done`=1 for the following cycle.
- DRAIN: counter decrements each cycle; when counter==1 -> HALTED. `i_stop_req`, `i_run_req`, `i_step_req`, `i_halt_detect` ignored.
- HALTED: clk_en=0, `o_halted`=1; only `i_clear` (-> IDLE, cycle count zeroed) or reset exits. Run/step ignored.
- Cycle counter: +1 on every cycle with clk_en=1, saturates at all-ones (no wrap).
- `i_clear` in any state other than HALTED has no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, `o_dunit_clk_en`=0, `o_halted`=0, `o_step_done`=0, `o_timeout`=0, `o_cycle_count`=0, drain counter=0.
- Command latency: a request sampled at edge k changes the state at edge k; clk_en is high during cycle k..k+1, and pipeline registers capture at edge k+1.
- One step = exactly one enabled cycle; `o_step_done` is high in the cycle after it, and a new `i_step_req` is accepted in that same cycle.
- HALT in RUN at edge k: clk_en stays high for DRAIN_CYCLES cycles after edge k, and `o_halted` rises at edge k+DRAIN_CYCLES.
- Reset mid-DRAIN or mid-RUN: immediate return to the reset values, and the counter is cleared.

## Configuration
- `DUNIT_WATCHDOG_EN` defined: in RUN, when `o_cycle_count` reaches CYCLE_LIMIT-1 and another enabled cycle occurs, the state goes to HALTED and `o_timeout` is set. `o_timeout` is sticky until `i_clear` or reset. DRAIN and STEP are not subject to the limit.
- Not defined: no comparator is built, `o_timeout` is tied 0, and RUN is unbounded.

## Test plan
- Reset mid-RUN: assert `i_reset` asynchronously -> outputs are at reset values before the next edge; count=0, state=0.
- IDLE, 3 `i_step_req` pulses spaced 4 cycles -> exactly 3 clk_en cycles, 3 `o_step_done` pulses, count=3.
- `i_run_req` for 10 cycles, then `i_stop_req` -> clk_en high 10 cycles, state=IDLE, count=10. A further `i_run_req` resumes counting from 10.
- RUN, `i_halt_detect` and `i_stop_req` in the same cycle (DRAIN_CYCLES=4) -> 4 more enabled cycles, `o_halted`=1, then `i_run_req` ignored; `i_clear` -> IDLE, count=0.
- STEP with `i_halt_detect`=1 -> DRAIN, 4 enabled cycles, HALTED, no `o_step_done`.
- Macro defined, CYCLE_LIMIT=20: run continuously -> HALTED with count=20, `o_timeout`=1 until `i_clear`.

Source files
------------

// File: rtl/dunit_pipe_sequencer.sv
// ============================================================================
// Module   : dunit_pipe_sequencer
// Purpose  : Debug-unit run/step/stop sequencer driving the MIPS pipeline
//            clock enable, with post-HALT drain and retired-cycle counter.
//            Optional macro DUNIT_WATCHDOG_EN adds a RUN-cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dunit_pipe_sequencer #(
  parameter int          NB_CNT       = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] CYCLE_LIMIT  = 32'd1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run_req,
  input  logic              i_step_req,
  input  logic              i_stop_req,
  input  logic              i_clear,
  input  logic              i_halt_detect,
  output logic              o_dunit_clk_en,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic              o_step_done,
  output logic              o_timeout,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] c_drain_load = 4'(DRAIN_CYCLES);

  state_t              r_state;
  logic [3:0]          r_drain_cnt;
  logic [NB_CNT-1:0]   r_count;
  logic                r_step_done;
  logic                w_clk_en;
  logic                w_wd_hit;

  // Enable is a pure decode of the state register: no input-to-output path.
  assign w_clk_en = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);

`ifdef DUNIT_WATCHDOG_EN
  logic r_timeout;

  assign w_wd_hit = (r_state == ST_RUN) && (r_count == NB_CNT'(CYCLE_LIMIT - 32'd1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else if (w_wd_hit) begin
      r_timeout <= 1'b1;
    end else if ((r_state == ST_HALTED) && i_clear) begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_wd_hit  = 1'b0;
  // Limit only matters with the watchdog; folded away to a constant zero here.
  assign o_timeout = 1'b0 & (|CYCLE_LIMIT);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 4'd0;
      r_count     <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      if (w_clk_en && !(&r_count)) begin
        r_count <= r_count + NB_CNT'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_run_req) begin
            r_state <= ST_RUN;
          end else if (i_step_req) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (w_wd_hit) begin
            r_state <= ST_HALTED;
          end else if (i_halt_detect) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= c_drain_load;
          end else if (i_stop_req) begin
            r_state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (i_halt_detect) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= c_drain_load;
          end else begin
            r_state     <= ST_IDLE;
            r_step_done <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 4'd1) begin
            r_state     <= ST_HALTED;
            r_drain_cnt <= 4'd0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        ST_HALTED: begin
          if (i_clear) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dunit_clk_en = w_clk_en;
  assign o_state        = r_state;
  assign o_halted       = (r_state == ST_HALTED);
  assign o_step_done    = r_step_done;
  assign o_cycle_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dunit_pipe_sequencer.sv
// ============================================================================
// Module   : tb_dunit_pipe_sequencer
// Purpose  : Directed self-checking bench for dunit_pipe_sequencer
//            (watchdog scenario active when DUNIT_WATCHDOG_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dunit_pipe_sequencer;

  localparam int c_nb_cnt = 32;
  localparam int c_drain  = 4;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_run_req, i_step_req, i_stop_req, i_clear, i_halt_detect;
  logic                o_dunit_clk_en;
  logic [2:0]          o_state;
  logic                o_halted, o_step_done, o_timeout;
  logic [c_nb_cnt-1:0] o_cycle_count;

  int total = 0;
  int bad   = 0;

  dunit_pipe_sequencer #(
    .NB_CNT       (c_nb_cnt),
    .DRAIN_CYCLES (c_drain),
    .CYCLE_LIMIT  (32'd20)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_run_req      (i_run_req),
    .i_step_req     (i_step_req),
    .i_stop_req     (i_stop_req),
    .i_clear        (i_clear),
    .i_halt_detect  (i_halt_detect),
    .o_dunit_clk_en (o_dunit_clk_en),
    .o_state        (o_state),
    .o_halted       (o_halted),
    .o_step_done    (o_step_done),
    .o_timeout      (o_timeout),
    .o_cycle_count  (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic all_idle();
    chk("state", 32'(o_state), 0);
    chk("clk_en", 32'(o_dunit_clk_en), 0);
  endtask

  initial begin
    i_reset = 1'b1; i_run_req = 1'b0; i_step_req = 1'b0; i_stop_req = 1'b0;
    i_clear = 1'b0; i_halt_detect = 1'b0;
    tick();
    all_idle();
    chk("rst_count", o_cycle_count, 0);
    chk("rst_halted", 32'(o_halted), 0);
    chk("rst_step_done", 32'(o_step_done), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    i_reset = 1'b0;
    tick();

    // Three single steps spaced four cycles apart.
    for (int s = 0; s < 3; s++) begin
      i_step_req = 1'b1; tick(); i_step_req = 1'b0;
      chk("step_state", 32'(o_state), 2);
      chk("step_en", 32'(o_dunit_clk_en), 1);
      tick();
      chk("step_done_hi", 32'(o_step_done), 1);
      chk("step_back_idle", 32'(o_state), 0);
      tick();
      chk("step_done_lo", 32'(o_step_done), 0);
      tick();
    end
    chk("step_count", o_cycle_count, 3);

    // Ten-cycle run then stop; stop in IDLE and clear outside HALTED are ignored.
    i_run_req = 1'b1; tick(); i_run_req = 1'b0;
    chk("run_state", 32'(o_state), 1);
    repeat (9) tick();
    i_stop_req = 1'b1; tick(); i_stop_req = 1'b0;
    all_idle();
    chk("run_count", o_cycle_count, 13);
    i_stop_req = 1'b1; i_clear = 1'b1; tick(); i_stop_req = 1'b0; i_clear = 1'b0;
    tick();
    chk("idle_hold_count", o_cycle_count, 13);

    // Resume, then halt and stop together: halt wins and the pipe drains.
    i_run_req = 1'b1; tick(); i_run_req = 1'b0;
    repeat (4) tick();
    chk("resume_count", o_cycle_count, 17);
    i_halt_detect = 1'b1; i_stop_req = 1'b1; tick();
    i_halt_detect = 1'b0; i_stop_req = 1'b0;
    chk("drain_state", 32'(o_state), 3);
    chk("drain_en", 32'(o_dunit_clk_en), 1);
    repeat (c_drain - 1) tick();
    chk("drain_last_state", 32'(o_state), 3);
    chk("drain_not_halted", 32'(o_halted), 0);
    tick();
    chk("halted_state", 32'(o_state), 4);
    chk("halted_flag", 32'(o_halted), 1);
    chk("halted_en", 32'(o_dunit_clk_en), 0);
    chk("halted_count", o_cycle_count, 22);
    i_run_req = 1'b1; i_step_req = 1'b1; tick(); i_run_req = 1'b0; i_step_req = 1'b0;
    tick();
    chk("halted_ignores_run", 32'(o_state), 4);
    chk("halted_count_hold", o_cycle_count, 22);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    all_idle();
    chk("clear_count", o_cycle_count, 0);
    chk("clear_halted", 32'(o_halted), 0);

    // Step that decodes HALT goes to DRAIN with no step_done.
    i_step_req = 1'b1; tick(); i_step_req = 1'b0;
    i_halt_detect = 1'b1; tick(); i_halt_detect = 1'b0;
    chk("stephalt_state", 32'(o_state), 3);
    chk("stephalt_no_done", 32'(o_step_done), 0);
    repeat (c_drain) tick();
    chk("stephalt_halted", 32'(o_state), 4);
    chk("stephalt_count", o_cycle_count, 5);
    chk("stephalt_no_done2", 32'(o_step_done), 0);
    i_clear = 1'b1; tick(); i_clear = 1'b0;

    // Asynchronous reset in the middle of RUN.
    i_run_req = 1'b1; tick(); i_run_req = 1'b0;
    tick(); tick();
    chk("pre_reset_count", o_cycle_count, 2);
    #2 i_reset = 1'b1;
    #1;
    all_idle();
    chk("async_rst_count", o_cycle_count, 0);
    tick();
    i_reset = 1'b0;
    tick();

`ifdef DUNIT_WATCHDOG_EN
    i_run_req = 1'b1; tick(); i_run_req = 1'b0;
    begin
      int n = 0;
      while (!o_halted && n < 100) begin
        tick();
        n++;
      end
      chk("wd_reached", 32'(o_halted), 1);
    end
    chk("wd_count", o_cycle_count, 20);
    chk("wd_timeout", 32'(o_timeout), 1);
    tick();
    chk("wd_sticky", 32'(o_timeout), 1);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    chk("wd_cleared", 32'(o_timeout), 0);
    chk("wd_idle", 32'(o_state), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
